// File: rtl/window3x3_stream_pkg.sv
// window3x3_stream_pkg: border modes, FSM states and ring-row helpers shared by the window generator.
package window3x3_stream_pkg;
  localparam int BORDER_REPLICATE = 0;
  localparam int BORDER_ZERO      = 1;

  typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_e;

  function automatic logic [1:0] ring_next(input logic [1:0] r);
    return (r == 2'd2) ? 2'd0 : r + 2'd1;
  endfunction

  function automatic logic [1:0] ring_prev(input logic [1:0] r);
    return (r == 2'd0) ? 2'd2 : r - 2'd1;
  endfunction
endpackage

// File: rtl/window3x3_stream_line_ring_buffer.sv
// window3x3_stream_line_ring_buffer: three line memories, one write port, reads of columns x-1, x, x+1 (clamped) across all rows.
module window3x3_stream_line_ring_buffer
  import window3x3_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMAGE_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 wr_en_i,
  input  logic [1:0]                           wr_row_i,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]       wr_col_i,
  input  logic [PIXEL_WIDTH-1:0]               wr_data_i,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]       rd_col_i,
  output logic [2:0][2:0][PIXEL_WIDTH-1:0]     rd_taps_o
);
  localparam int XW = $clog2(IMAGE_WIDTH);

  logic [PIXEL_WIDTH-1:0] mem_q [3][IMAGE_WIDTH];
  logic [XW-1:0]          col_l, col_r;

  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wr_row_i][wr_col_i] <= wr_data_i;

  assign col_l = (rd_col_i == '0) ? rd_col_i : rd_col_i - 1'b1;
  assign col_r = (rd_col_i == XW'(IMAGE_WIDTH - 1)) ? rd_col_i : rd_col_i + 1'b1;

  // Reads are combinational so a same-cycle write to the column still returns the old row.
  for (genvar r = 0; r < 3; r++) begin : g_row
    assign rd_taps_o[r] = {mem_q[r][col_r], mem_q[r][rd_col_i], mem_q[r][col_l]};
  end
endmodule

// File: rtl/window3x3_stream.sv
// window3x3_stream: raster-order pixel stream in, 3x3 neighbourhood per pixel out, with replicate or zero borders.
module window3x3_stream
  import window3x3_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int BORDER_MODE  = BORDER_REPLICATE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [PIXEL_WIDTH-1:0]   i_pixel,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [9*PIXEL_WIDTH-1:0] o_window,
  output logic                     o_last
);
  localparam int PW = PIXEL_WIDTH;
  localparam int W  = IMAGE_WIDTH;
  localparam int H  = IMAGE_HEIGHT;
  localparam int N  = W * H;
  localparam int CW = $clog2(N + 1);
  localparam int TW = CW + 1;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic [CW-1:0]           in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, ld_cnt_q, ld_cnt_d;
  logic [XW-1:0]           ix_q, ix_d, lx_q, lx_d;
  logic [YW-1:0]           ly_q, ly_d;
  logic [1:0]              irow_q, irow_d, lrow_q, lrow_d, row_up, row_dn;
  state_e                  st_q, st_d;
  logic                    o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [9*PW-1:0]         win_q, win_d, win;
  logic [2:0][2:0][PW-1:0] rd;
  logic [TW-1:0]           thr;
  logic                    acc, hs, avail, load, frame_end, ix_end, lx_end, ly_top, ly_end;

  assign i_ready   = (st_q != DRAIN) && (in_cnt_q - out_cnt_q <= CW'(2 * W - 2));
  assign acc       = i_valid && i_ready;
  assign hs        = o_valid_q && o_ready;
  assign frame_end = hs && o_last_q;
  assign ix_end    = ix_q == XW'(W - 1);
  assign lx_end    = lx_q == XW'(W - 1);
  assign ly_top    = ly_q == '0;
  assign ly_end    = ly_q == YW'(H - 1);

  // ld_cnt tracks the next window to load; its bottom-right needed pixel sits W+1 ahead, less at the clamped edges.
  assign thr   = TW'(ld_cnt_q) + (ly_end ? TW'(0) : TW'(W)) + TW'(!lx_end);
  assign avail = (ld_cnt_q != CW'(N)) && (TW'(in_cnt_q) > thr);
  assign load  = avail && (!o_valid_q || o_ready);

  assign row_up = ly_top ? lrow_q : ring_prev(lrow_q);
  assign row_dn = ly_end ? lrow_q : ring_next(lrow_q);

  window3x3_stream_line_ring_buffer #(
    .PIXEL_WIDTH (PW),
    .IMAGE_WIDTH (W)
  ) u_ring (
    .clk       (clk),
    .wr_en_i   (acc),
    .wr_row_i  (irow_q),
    .wr_col_i  (ix_q),
    .wr_data_i (i_pixel),
    .rd_col_i  (lx_q),
    .rd_taps_o (rd)
  );

  always_comb begin
    win = '0;
    for (int c = 0; c < 3; c++) begin
      win[c*PW +: PW]     = rd[row_up][c];
      win[(3+c)*PW +: PW] = rd[lrow_q][c];
      win[(6+c)*PW +: PW] = rd[row_dn][c];
    end
    if (BORDER_MODE == BORDER_ZERO) begin
      if (ly_top) win[3*PW-1:0] = '0;
      if (ly_end) win[9*PW-1:6*PW] = '0;
      for (int r = 0; r < 3; r++) begin
        if (lx_q == '0) win[3*r*PW +: PW] = '0;
        if (lx_end) win[(3*r+2)*PW +: PW] = '0;
      end
    end
  end

  always_comb begin
    in_cnt_d  = frame_end ? '0 : in_cnt_q + CW'(acc);
    out_cnt_d = frame_end ? '0 : out_cnt_q + CW'(hs);
    ld_cnt_d  = frame_end ? '0 : ld_cnt_q + CW'(load);
    ix_d      = frame_end ? '0 : !acc ? ix_q : ix_end ? '0 : ix_q + 1'b1;
    irow_d    = frame_end ? '0 : (acc && ix_end) ? ring_next(irow_q) : irow_q;
    lx_d      = frame_end ? '0 : !load ? lx_q : lx_end ? '0 : lx_q + 1'b1;
    ly_d      = frame_end ? '0 : (load && lx_end) ? ly_q + 1'b1 : ly_q;
    lrow_d    = frame_end ? '0 : (load && lx_end) ? ring_next(lrow_q) : lrow_q;
    o_valid_d = load || (o_valid_q && !o_ready);
    o_last_d  = load ? (lx_end && ly_end) : (o_last_q && !o_ready);
    win_d     = load ? win : win_q;
    st_d      = frame_end ? FILL :
                (acc && in_cnt_q == CW'(N - 1)) ? DRAIN :
                (st_q == FILL && load) ? STREAM : st_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ld_cnt_q  <= '0;
      ix_q      <= '0;
      irow_q    <= '0;
      lx_q      <= '0;
      ly_q      <= '0;
      lrow_q    <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      win_q     <= '0;
      st_q      <= FILL;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      ix_q      <= ix_d;
      irow_q    <= irow_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      lrow_q    <= lrow_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      win_q     <= win_d;
      st_q      <= st_d;
    end

  assign o_valid  = o_valid_q;
  assign o_last   = o_last_q;
  assign o_window = win_q;
endmodule

// File: tb/tb_window3x3_stream.sv
// tb_window3x3_stream: random-stimulus bench for both border modes against a frame-array window model.
module tb_window3x3_stream;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic o_ready = 1'b0;
  logic [PW-1:0] i_pixel = '0;
  logic ir[2], ov[2], ol[2];
  logic [9*PW-1:0] ow[2];

  window3x3_stream #(.PIXEL_WIDTH(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[0]), .i_pixel(i_pixel),
    .o_valid(ov[0]), .o_ready(o_ready), .o_window(ow[0]), .o_last(ol[0]));
  window3x3_stream #(.PIXEL_WIDTH(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(ir[1]), .i_pixel(i_pixel),
    .o_valid(ov[1]), .o_ready(o_ready), .o_window(ow[1]), .o_last(ol[1]));

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  logic [PW-1:0] acc_log[$];
  logic [PW-1:0] src[$];
  logic [9*PW-1:0] wlog0[$], wlog1[$], s1[$];
  logic llog0[$];
  int nout[2], m_in[2], m_out[2];
  bit held[2];
  logic [9*PW-1:0] hw[2];
  logic hl[2];
  bit pop_pending = 0;
  int vprob = 100, rprob = 100;
  int cyc = 0, a5 = -1, first_ov = -1;

  task automatic chk(input string nm, input logic [9*PW-1:0] act, input logic [9*PW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9*PW-1:0] pk(input int a0, a1, a2, a3, a4, a5v, a6, a7, a8);
    return {PW'(a8), PW'(a7), PW'(a6), PW'(a5v), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
  endfunction

  // Window j of the run, taken straight from the accepted-pixel history by coordinate arithmetic.
  function automatic logic [9*PW-1:0] model_win(input int j, input int mode);
    int f, k, x, y, xx, yy, base, need;
    logic [9*PW-1:0] r;
    f = j / N; k = j % N; x = k % W; y = k / W; base = f * N;
    need = base + ((y + 1 < H) ? y + 1 : H - 1) * W + ((x + 1 < W) ? x + 1 : W - 1);
    if (need >= acc_log.size()) return 'x;
    r = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        xx = x + dx; yy = y + dy;
        if (mode == 0 || !(xx < 0 || xx >= W || yy < 0 || yy >= H)) begin
          xx = xx < 0 ? 0 : (xx >= W ? W - 1 : xx);
          yy = yy < 0 ? 0 : (yy >= H ? H - 1 : yy);
          r[((dy + 1) * 3 + dx + 1) * PW +: PW] = acc_log[base + yy * W + xx];
        end
      end
    return r;
  endfunction

  always @(negedge clk) begin
    bit exp_ir;
    logic [9*PW-1:0] ew;
    cyc++;
    if (rst_n)
      for (int d = 0; d < 2; d++) begin
        exp_ir = (m_in[d] < N) && (m_in[d] - m_out[d] <= 2 * W - 2);
        chk($sformatf("i_ready[%0d]", d), ir[d], exp_ir);
        if (held[d]) begin
          chk($sformatf("hold_window[%0d]", d), ow[d], hw[d]);
          chk($sformatf("hold_last[%0d]", d), ol[d], hl[d]);
          chk($sformatf("hold_valid[%0d]", d), ov[d], 1);
        end
        if (i_valid && ir[d]) begin
          if (d == 0) begin
            if (m_in[0] == 5) a5 = cyc;
            acc_log.push_back(i_pixel);
            pop_pending = 1;
          end
          m_in[d]++;
        end
        if (d == 0 && ov[0] && first_ov < 0) first_ov = cyc;
        if (ov[d] && o_ready) begin
          ew = model_win(nout[d], d);
          chk($sformatf("window[%0d] #%0d", d, nout[d]), ow[d], ew);
          chk($sformatf("last[%0d] #%0d", d, nout[d]), ol[d], (nout[d] % N) == N - 1);
          if (d == 0) begin wlog0.push_back(ow[0]); llog0.push_back(ol[0]); end
          else wlog1.push_back(ow[1]);
          if (nout[d] % N == N - 1) begin m_in[d] = 0; m_out[d] = 0; end
          else m_out[d]++;
          nout[d]++;
        end
        held[d] = ov[d] && !o_ready;
        hw[d] = ow[d];
        hl[d] = ol[d];
      end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pending) begin
      if (src.size() != 0) void'(src.pop_front());
      pop_pending = 0;
    end
    i_valid = (src.size() != 0) && ($urandom_range(99) < vprob);
    i_pixel = (src.size() != 0) ? src[0] : '0;
    o_ready = $urandom_range(99) < rprob;
  endtask

  task automatic load_frame(input int off);
    for (int i = 0; i < N; i++) src.push_back(PW'(i + off));
  endtask

  task automatic run_until(input int target, input int budget);
    int c = 0;
    while (nout[0] < target && c < budget) begin step(); c++; end
    chk("windows_reached", nout[0], target);
  endtask

  initial begin
    int base, c, lasts;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_o_valid", ov[d], 0);
      chk("rst_o_last", ol[d], 0);
      chk("rst_o_window", ow[d], 0);
    end
    #10 rst_n = 1'b1;
    #1;
    chk("post_rst_i_ready0", ir[0], 1);
    chk("post_rst_i_ready1", ir[1], 1);

    // replicate/zero corners, latency
    first_ov = -1; base = nout[0]; load_frame(0);
    run_until(base + 16, 200);
    chk("first_window_latency", first_ov - a5, 2);
    chk("rep_w00", wlog0[base], pk(0, 0, 1, 0, 0, 1, 4, 4, 5));
    chk("rep_w33", wlog0[base + 15], pk(10, 11, 11, 14, 15, 15, 14, 15, 15));
    chk("rep_last33", llog0[base + 15], 1);
    chk("zero_w00", wlog1[base], pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
    chk("rep_w11", wlog0[base + 5], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("zero_w11", wlog1[base + 5], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
    for (int k = 0; k < N; k++) s1.push_back(wlog0[base + k]);

    // output backpressure at (1,1)
    base = nout[0]; load_frame(0); c = 0;
    while (nout[0] < base + 5 && c < 200) begin step(); c++; end
    chk("bp_reach_11", nout[0], base + 5);
    rprob = 0; o_ready = 1'b0;
    repeat (10) step();
    chk("bp_i_ready_low", ir[0], 0);
    chk("bp_lag", m_in[0] - m_out[0], 2 * W - 1);
    chk("bp_o_valid", ov[0], 1);
    rprob = 100;
    run_until(base + 16, 200);
    for (int k = 0; k < N; k++) chk("bp_seq", wlog0[base + k], s1[k]);

    // input bubbles
    vprob = 50; base = nout[0]; load_frame(0);
    run_until(base + 16, 400);
    repeat (20) step();
    chk("bubble_count", nout[0] - base, 16);
    for (int k = 0; k < N; k++) chk("bubble_seq", wlog0[base + k], s1[k]);

    // random pixels, random ready
    vprob = 70; rprob = 60; base = nout[0];
    for (int i = 0; i < 3 * N; i++) src.push_back(PW'($urandom));
    run_until(base + 3 * N, 2000);

    // reset mid-frame
    vprob = 100; rprob = 100; load_frame(0); c = 0;
    while (m_in[0] < 9 && c < 100) begin step(); c++; end
    chk("pre_reset_o_valid", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_o_valid0", ov[0], 0);
    chk("async_rst_o_valid1", ov[1], 0);
    i_valid = 1'b0;
    src.delete(); acc_log.delete(); wlog0.delete(); wlog1.delete(); llog0.delete();
    pop_pending = 0;
    for (int d = 0; d < 2; d++) begin nout[d] = 0; m_in[d] = 0; m_out[d] = 0; held[d] = 0; end
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    load_frame(0);
    run_until(16, 200);
    chk("rst_rep_w00", wlog0[0], pk(0, 0, 1, 0, 0, 1, 4, 4, 5));
    chk("rst_zero_w00", wlog1[0], pk(0, 0, 0, 0, 0, 1, 0, 4, 5));

    // back-to-back frames
    base = nout[0]; load_frame(0); load_frame(16);
    run_until(base + 32, 300);
    chk("b2b_w00_f2", wlog0[base + 16], pk(16, 16, 17, 16, 16, 17, 20, 20, 21));
    lasts = 0;
    for (int k = 0; k < 32; k++) if (llog0[base + k] === 1'b1) lasts++;
    chk("b2b_last_pulses", lasts, 2);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
